// File: rtl/inv_multiplica_colunas.sv
// inv_multiplica_colunas: iterative AES InvMixColumns engine.
// Accepts one 128-bit state over valid/ready. It then computes COLS_PER_CYCLE
// columns per clock into a registered output. That output is held until the
// consumer takes it.
module inv_multiplica_colunas #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] bloco,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] saida
);

  // Only 1, 2 or 4 columns per clock divide the four columns evenly.
  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("inv_multiplica_colunas: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  // Column counter step and the column index that finishes the block.
  // Both are taken modulo 4 so that the 4-column case wraps straight back to 0.
  localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE % 4);
  localparam logic [1:0] COL_LAST = 2'(4 - COLS_PER_CYCLE);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } estado_t;

  estado_t      estado;
  logic [1:0]   col;
  logic [127:0] copia;
  logic [127:0] saida_nxt;
  int           c_idx;
  logic [31:0]  col_in;
  logic [31:0]  col_out;

  // GF(2^8) doubling modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul_09(input logic [7:0] x);
    logic [7:0] x2, x4, x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x;
  endfunction

  function automatic logic [7:0] mul_0b(input logic [7:0] x);
    logic [7:0] x2, x4, x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x2 ^ x;
  endfunction

  function automatic logic [7:0] mul_0d(input logic [7:0] x);
    logic [7:0] x2, x4, x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x;
  endfunction

  function automatic logic [7:0] mul_0e(input logic [7:0] x);
    logic [7:0] x2, x4, x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

  // InvMixColumns on one column, packed as {row0, row1, row2, row3}.
  function automatic logic [31:0] inv_coluna(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = a;
    return {mul_0e(a0) ^ mul_0b(a1) ^ mul_0d(a2) ^ mul_09(a3),
            mul_09(a0) ^ mul_0e(a1) ^ mul_0b(a2) ^ mul_0d(a3),
            mul_0d(a0) ^ mul_09(a1) ^ mul_0e(a2) ^ mul_0b(a3),
            mul_0b(a0) ^ mul_0d(a1) ^ mul_09(a2) ^ mul_0e(a3)};
  endfunction

  // Next value of saida: columns col..col+COLS_PER_CYCLE-1 are replaced.
  // All other bytes are carried over unchanged.
  always_comb begin
    // NOTE: every variable gets a default before any conditional or loop write,
    // otherwise paths that skip the write would infer a latch.
    saida_nxt = saida;
    c_idx     = 0;
    col_in    = '0;
    col_out   = '0;
    for (int i = 0; i < COLS_PER_CYCLE; i++) begin
      // Masked to 0..3 so unreachable col/i combinations never index past the block.
      c_idx   = (int'(col) + i) & 3;
      col_in  = {copia[127 - 8*c_idx        -: 8],
                 copia[127 - 8*(c_idx + 4)  -: 8],
                 copia[127 - 8*(c_idx + 8)  -: 8],
                 copia[127 - 8*(c_idx + 12) -: 8]};
      col_out = inv_coluna(col_in);
      saida_nxt[127 - 8*c_idx        -: 8] = col_out[31:24];
      saida_nxt[127 - 8*(c_idx + 4)  -: 8] = col_out[23:16];
      saida_nxt[127 - 8*(c_idx + 8)  -: 8] = col_out[15:8];
      saida_nxt[127 - 8*(c_idx + 12) -: 8] = col_out[7:0];
    end
  end

  // Control FSM plus the input copy and the output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the wide data registers are reset as well. That way a reset
      // mid-block leaves neither the old output nor the old copy visible.
      estado    <= IDLE;
      col       <= '0;
      out_valid <= 1'b0;
      saida     <= '0;
      copia     <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout. Every register then sees
      // the pre-edge values of the others, whatever order they appear in.
      case (estado)
        IDLE: begin
          if (in_valid) begin
            copia  <= bloco;
            col    <= '0;
            estado <= CALC;
          end
        end
        CALC: begin
          saida <= saida_nxt;
          if (col == COL_LAST) begin
            col       <= '0;
            out_valid <= 1'b1;
            estado    <= DONE;
          end else begin
            col <= col + COL_STEP;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            estado    <= IDLE;
          end
        end
        default: estado <= IDLE;
      endcase
    end
  end

  assign in_ready = (estado == IDLE);

endmodule

// File: doc/inv_multiplica_colunas.md
# inv_multiplica_colunas

Iterative AES InvMixColumns engine for the decryption datapath, the inverse of the team's forward MixColumns transform. It accepts one 128-bit state block over a valid/ready handshake and processes COLS_PER_CYCLE columns per clock. It presents the result on a registered output held until the consumer takes it. It sits between InvShiftRows/InvSubBytes and the AddRoundKey stage of the decryption round.

## Interface
- COLS_PER_CYCLE, 1, columns computed per clock; legal values 1, 2, 4; anything else is a synthesis error.
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  bloco is valid.
- in_ready  output  1  engine can accept a block.
- bloco  input  128  input state.
- out_valid  output  1  saida holds a finished block.
- out_ready  input  1  consumer takes saida.
- saida  output  128  InvMixColumns(bloco), registered.

## Operation
- Byte layout: byte k is bloco[127-8k -: 8] (k=0 at [127:120]); k = 4*row + col; column c = bytes c, c+4, c+8, c+12 (rows 0..3).
- Per column (a0..a3 = rows 0..3):
  - out0 = 0E·a0 ^ 0B·a1 ^ 0D·a2 ^ 09·a3
  - out1 = 09·a0 ^ 0E·a1 ^ 0B·a2 ^ 0D·a3
  - out2 = 0D·a0 ^ 09·a1 ^ 0E·a2 ^ 0B·a3
  - out3 = 0B·a0 ^ 0D·a1 ^ 09·a2 ^ 0E·a3
- GF(2^8) arithmetic uses polynomial 0x11B. xtime(x) = (x<<1)[7:0] ^ (x[7] ? 8'h1B : 0).
  - x2 = xtime(x), x4 = xtime(x2), x8 = xtime(x4).
  - 09 = x8^x; 0B = x8^x2^x; 0D = x8^x4^x; 0E = x8^x4^x2.
  - All intermediates are 8 bits wide.
- State machine:
  - IDLE: in_ready=1. On in_valid, latch bloco into the internal state register, set col=0, go to CALC.
  - CALC: each clock, compute columns col..col+COLS_PER_CYCLE-1 from the latched copy and write them into the saida register in place. Advance col by COLS_PER_CYCLE. When the last column is written, go to DONE and set out_valid=1 on the same edge.
  - DONE: hold saida and out_valid. On out_ready, clear out_valid and go to IDLE.
- in_ready = (state==IDLE). in_valid is ignored outside IDLE. bloco changes after acceptance have no effect.
- col is a 2-bit counter and wraps to 0 on leaving CALC.
- saida bytes of columns not yet processed keep their previous values until overwritten. Only saida while out_valid=1 is defined.
- Reset (at any time, including mid-CALC or in DONE):
  - state=IDLE, col=0, out_valid=0, saida=128'h0, internal state register=0.
  - The in-flight block is discarded.
  - in_ready=1 while rst is high and after release.

## Timing
- Accept edge E0 (IDLE, in_valid=1). CALC occupies N = 4/COLS_PER_CYCLE edges, E1..EN.
- out_valid rises after EN, so latency is N cycles from accept to out_valid (4, 2 or 1).
- Output handshake on the first edge in DONE with out_ready=1. in_ready rises after that edge. The next accept is no earlier than the edge after that.
- Back-to-back throughput with out_ready held high is one block per N+2 cycles.
- out_ready while out_valid=0 has no effect. out_valid never drops without a handshake or reset.
- No combinational path from any input to any output except through state; in_ready and out_valid are decoded from state registers.

## Test plan
- Known column, COLS_PER_CYCLE=1:
  - Stimulus: bloco=128'h8e8e8e8e_4d4d4d4d_a1a1a1a1_bcbcbcbc.
  - Response: saida=128'hdbdbdbdb_13131313_53535353_45454545; out_valid exactly 4 cycles after accept.
- Mixed columns, each value of COLS_PER_CYCLE:
  - Stimulus: columns (9f,dc,58,9d), (01,01,01,01), (c6,c6,c6,c6), (d5,d5,d7,d6) placed in cols 0..3.
  - Response: columns (f2,0a,22,5c), (01,01,01,01), (c6,c6,c6,c6), (d4,d4,d4,d5).
  - Latency 4, 2, 1 respectively.
- Backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles after out_valid; pulse in_valid with a different bloco during that time.
  - Response: saida stable, in_ready=0, the second block is not accepted. It is accepted in IDLE after the handshake.
- Reset mid-CALC:
  - Stimulus: assert rst after 2 CALC edges.
  - Response: out_valid=0 and saida=0 immediately (asynchronous). A fresh block afterwards gives a correct result with full latency.
- Round trip:
  - Stimulus: 1000 random blocks through the bench's forward MixColumns model, then this block, with random in_valid/out_ready gaps.
  - Response: output equals the original block every time; no block dropped or duplicated.
- All-zero and all-FF:
  - Stimulus: 128'h0, then 128'hFF…FF.
  - Response: 128'h0, then 128'hFF…FF (the row coefficients XOR to 1).
